// File: rtl/postprocess_pkg.sv
// postprocess_pkg
//   Shared constants and constant functions for the post-processing pipe.
//   Widths are derived from the lane data width DW and the number of
//   fractional bits FRAC so that every parameterisation of the lane agrees
//   on product, sum, rounding and clamp values.
//   Build option: POSTPROC_SAT_CNT_EN (used by postprocess_pipe only).
package postprocess_pkg;

    localparam int unsigned POX_DEF  = 3;
    localparam int unsigned DW_DEF   = 16;
    localparam int unsigned FRAC_DEF = 8;

    // Full-precision signed product x*K.
    function automatic int unsigned prod_w(input int unsigned dw);
        return 2 * dw;
    endfunction

    // Product plus aligned bias, one guard bit for the add.
    function automatic int unsigned sum_w(input int unsigned dw);
        return 2 * dw + 1;
    endfunction

    // Sum plus the round-half-up constant, one more guard bit.
    function automatic int unsigned rnd_w(input int unsigned dw);
        return 2 * dw + 2;
    endfunction

    // Half an LSB of the output; zero when there are no fractional bits.
    function automatic longint round_const(input int unsigned frac);
        if (frac == 0) begin
            return 64'sd0;
        end
        return 64'sd1 <<< (frac - 1);
    endfunction

    function automatic longint sat_max(input int unsigned dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int unsigned dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/postprocess_lane.sv
// postprocess_lane
//   One lane of the affine post-processing datapath, three registered stages:
//     S1: p = x*K (signed, full width), bias captured alongside
//     S2: y = sat(round((p + (B<<FRAC)) >> FRAC)), sat flag
//     S3: optional ReLU, output register
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     en           advance all stages (global stall when low)
//     x, k, b      lane input, scale and bias of the beat entering S1
//     relu         ReLU enable of the beat currently held in S2
//     y            lane result (S3 register)
//     sat          clamp occurred for the beat currently held in S2
module postprocess_lane
    import postprocess_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] k,
    input  logic [DW-1:0] b,
    input  logic          relu,
    output logic [DW-1:0] y,
    output logic          sat
);

    localparam int unsigned PW = prod_w(DW);
    localparam int unsigned RW = rnd_w(DW);

    localparam logic signed [RW-1:0] RND  = RW'(round_const(FRAC));
    localparam logic signed [RW-1:0] SMAX = RW'(sat_max(DW));
    localparam logic signed [RW-1:0] SMIN = RW'(sat_min(DW));

    logic signed [PW-1:0] p_q, p_d;
    logic        [DW-1:0] b1_q, b1_d;
    logic        [DW-1:0] y2_q, y2_d;
    logic                 sat_q, sat_d;
    logic        [DW-1:0] y_q, y_d;

    logic signed [PW-1:0] prod;
    logic signed [RW-1:0] bias_al;
    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] r;
    logic        [DW-1:0] y2_calc;
    logic                 sat_calc;

    always_comb begin
        p_d      = p_q;
        b1_d     = b1_q;
        y2_d     = y2_q;
        sat_d    = sat_q;
        y_d      = y_q;
        prod     = $signed(x) * $signed(k);
        bias_al  = $signed({{(RW-DW){b1_q[DW-1]}}, b1_q}) <<< FRAC;
        // RND is zero when FRAC=0, so the shift below degenerates to r = s.
        sum      = $signed({{(RW-PW){p_q[PW-1]}}, p_q}) + bias_al + RND;
        r        = sum >>> FRAC;
        y2_calc  = r[DW-1:0];
        sat_calc = 1'b0;
        if (r > SMAX) begin
            y2_calc  = SMAX[DW-1:0];
            sat_calc = 1'b1;
        end else if (r < SMIN) begin
            y2_calc  = SMIN[DW-1:0];
            sat_calc = 1'b1;
        end
        if (en) begin
            p_d   = prod;
            b1_d  = b;
            y2_d  = y2_calc;
            sat_d = sat_calc;
            y_d   = (relu && y2_q[DW-1]) ? '0 : y2_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q   <= '0;
            b1_q  <= '0;
            y2_q  <= '0;
            sat_q <= 1'b0;
            y_q   <= '0;
        end else begin
            p_q   <= p_d;
            b1_q  <= b1_d;
            y2_q  <= y2_d;
            sat_q <= sat_d;
            y_q   <= y_d;
        end
    end

    assign y   = y_q;
    assign sat = sat_q;

endmodule

// File: rtl/postprocess_pipe.sv
// postprocess_pipe
//   POX-lane folded batch-norm/bias post-processing with optional ReLU,
//   y = sat(round((x*K + (B<<FRAC)) >> FRAC)), 3-cycle latency, full
//   valid/ready backpressure through a single global stall.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     mux_postprocess_data     lane x values, lane i = [i*DW +: DW]
//     mux_postprocess_valid    input beat valid
//     mux_postprocess_ready    pipe can accept a beat this cycle
//     K, B                     per-lane scale and bias, sampled with the beat
//     relu_en                  ReLU enable, sampled with the beat
//     post_out                 result lanes
//     post_out_valid           output beat valid
//     post_out_ready           downstream accepts the beat
//   Build option POSTPROC_SAT_CNT_EN adds:
//     sat_cnt_clr              synchronous clear of the saturation counter
//     sat_cnt                  saturating count of clamped lanes
module postprocess_pipe
    import postprocess_pkg::*;
#(
    parameter int unsigned POX  = POX_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [POX*DW-1:0] mux_postprocess_data,
    input  logic              mux_postprocess_valid,
    output logic              mux_postprocess_ready,
    input  logic [POX*DW-1:0] K,
    input  logic [POX*DW-1:0] B,
    input  logic              relu_en,
    output logic [POX*DW-1:0] post_out,
    output logic              post_out_valid,
    input  logic              post_out_ready
`ifdef POSTPROC_SAT_CNT_EN
    ,
    input  logic              sat_cnt_clr,
    output logic [31:0]       sat_cnt
`endif
);

    logic           en;
    logic           v1_q, v1_d;
    logic           v2_q, v2_d;
    logic           v3_q, v3_d;
    logic           relu1_q, relu1_d;
    logic           relu2_q, relu2_d;
    logic [POX-1:0] sat_vec;

    // One stall for the whole pipe: only a full, blocked S3 holds it.
    assign en                    = ~v3_q | post_out_ready;
    assign mux_postprocess_ready = en;

    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        relu1_d = relu1_q;
        relu2_d = relu2_q;
        if (en) begin
            v1_d    = mux_postprocess_valid;
            v2_d    = v1_q;
            v3_d    = v2_q;
            relu1_d = relu_en;
            relu2_d = relu1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            relu1_q <= 1'b0;
            relu2_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            relu1_q <= relu1_d;
            relu2_q <= relu2_d;
        end
    end

    assign post_out_valid = v3_q;

    for (genvar i = 0; i < POX; i++) begin : g_lane
        postprocess_lane #(
            .DW   (DW),
            .FRAC (FRAC)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .x    (mux_postprocess_data[i*DW +: DW]),
            .k    (K[i*DW +: DW]),
            .b    (B[i*DW +: DW]),
            .relu (relu2_q),
            .y    (post_out[i*DW +: DW]),
            .sat  (sat_vec[i])
        );
    end

`ifdef POSTPROC_SAT_CNT_EN
    logic [31:0] sat_cnt_q, sat_cnt_d;
    logic [31:0] sat_pop;
    logic [32:0] sat_sum;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        sat_pop   = '0;
        for (int unsigned i = 0; i < POX; i++) begin
            sat_pop = sat_pop + 32'(sat_vec[i]);
        end
        sat_sum = {1'b0, sat_cnt_q} + {1'b0, sat_pop};
        if (sat_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (en && v2_q) begin
            sat_cnt_d = sat_sum[32] ? '1 : sat_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic unused_sat;
    assign unused_sat = ^sat_vec;
`endif

endmodule

// File: tb/tb_postprocess_pipe.sv
module tb_postprocess_pipe;

    localparam int unsigned POX  = 3;
    localparam int unsigned DW   = 16;
    localparam int unsigned FRAC = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [POX*DW-1:0] mux_postprocess_data = '0;
    logic              mux_postprocess_valid = 1'b0;
    logic              mux_postprocess_ready;
    logic [POX*DW-1:0] K = '0;
    logic [POX*DW-1:0] B = '0;
    logic              relu_en = 1'b0;
    logic [POX*DW-1:0] post_out;
    logic              post_out_valid;
    logic              post_out_ready = 1'b1;
`ifdef POSTPROC_SAT_CNT_EN
    logic              sat_cnt_clr = 1'b0;
    logic [31:0]       sat_cnt;
`endif

    postprocess_pipe #(
        .POX  (POX),
        .DW   (DW),
        .FRAC (FRAC)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .mux_postprocess_data  (mux_postprocess_data),
        .mux_postprocess_valid (mux_postprocess_valid),
        .mux_postprocess_ready (mux_postprocess_ready),
        .K                     (K),
        .B                     (B),
        .relu_en               (relu_en),
        .post_out              (post_out),
        .post_out_valid        (post_out_valid),
        .post_out_ready        (post_out_ready)
`ifdef POSTPROC_SAT_CNT_EN
        ,
        .sat_cnt_clr           (sat_cnt_clr),
        .sat_cnt               (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Lanes packed {lane2, lane1, lane0}; y values computed by hand.
    typedef struct {
        logic [47:0] x;
        logic [47:0] k;
        logic [47:0] b;
        logic        relu;
        logic [47:0] y;
    } vec_t;

    vec_t vt[7];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [47:0] exp_q[$];
    bit          trk = 1'b0;
    int          npop = 0;
    int          first_pop = 0;
    int          last_pop = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: whenever a beat is presented it must match the oldest
    // expected beat; held beats are checked every stalled cycle too.
    always @(negedge clk) begin
        if (rst && post_out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious", 64'(post_out_valid), 64'd0);
            end else begin
                chk("post_out", 64'(post_out), 64'(exp_q[0]));
                if (post_out_ready) begin
                    void'(exp_q.pop_front());
                    if (trk) begin
                        if (npop == 0) first_pop = cyc;
                        last_pop = cyc;
                        npop++;
                    end
                end
            end
        end
    end

    task automatic send(input int i);
        bit acc = 1'b0;
        int t = 0;
        mux_postprocess_data  = vt[i].x;
        K                     = vt[i].k;
        B                     = vt[i].b;
        relu_en               = vt[i].relu;
        mux_postprocess_valid = 1'b1;
        exp_q.push_back(vt[i].y);
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = mux_postprocess_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        vt[0] = '{x: {16'hFFFF, 16'h0001, 16'h0100}, k: {16'h0080, 16'h0080, 16'h0200},
                  b: {16'h0000, 16'h0000, 16'h0005}, relu: 1'b0,
                  y: {16'h0000, 16'h0001, 16'h0205}};
        vt[1] = '{x: {16'hFF00, 16'h8000, 16'h7FFF}, k: {16'h0200, 16'h7FFF, 16'h7FFF},
                  b: 48'h0, relu: 1'b0,
                  y: {16'hFE00, 16'h8000, 16'h7FFF}};
        vt[2] = '{x: {16'hFF00, 16'h8000, 16'h7FFF}, k: {16'h0200, 16'h7FFF, 16'h7FFF},
                  b: 48'h0, relu: 1'b1,
                  y: {16'h0000, 16'h0000, 16'h7FFF}};
        vt[3] = '{x: {16'h0003, 16'hFFFF, 16'h0000}, k: {16'h0080, 16'h0180, 16'h0000},
                  b: {16'h0000, 16'h0000, 16'hFFFF}, relu: 1'b0,
                  y: {16'h0002, 16'hFFFF, 16'hFFFF}};
        vt[4] = '{x: {16'h0200, 16'h0000, 16'h0000}, k: {16'h0100, 16'h0000, 16'h0000},
                  b: {16'hFFFE, 16'h8000, 16'h7FFF}, relu: 1'b0,
                  y: {16'h01FE, 16'h8000, 16'h7FFF}};
        vt[5] = '{x: {16'h0180, 16'h0000, 16'h0100}, k: {16'h0100, 16'h0000, 16'h0200},
                  b: {16'h0000, 16'hFFFF, 16'h0005}, relu: 1'b1,
                  y: {16'h0180, 16'h0000, 16'h0205}};
        vt[6] = '{x: {16'h7FFF, 16'h7FFF, 16'h7FFF}, k: {16'h7FFF, 16'h7FFF, 16'h7FFF},
                  b: 48'h0, relu: 1'b0,
                  y: {16'h7FFF, 16'h7FFF, 16'h7FFF}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(post_out_valid), 64'd0);
        chk("rst_data", 64'(post_out), 64'd0);
        rst = 1'b1;
        chk("ready_after_rst", 64'(mux_postprocess_ready), 64'd1);

        // First acceptance on the first edge after release, 3-cycle latency
        c0 = cyc;
        send(0);
        mux_postprocess_valid = 1'b0;
        chk("first_accept", 64'(cyc - c0), 64'd1);
        chk("lat_c1", 64'(post_out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_c2", 64'(post_out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_c3", 64'(post_out_valid), 64'd1);
        wait_drain();

        // Individual directed vectors
        for (int i = 1; i < 6; i++) begin
            send(i);
            mux_postprocess_valid = 1'b0;
            wait_drain();
        end

        // 10-beat stream: one output per cycle
        trk = 1'b1;
        npop = 0;
        for (int i = 0; i < 10; i++) send(i % 6);
        mux_postprocess_valid = 1'b0;
        wait_drain();
        trk = 1'b0;
        chk("tput_count", 64'(npop), 64'd10);
        chk("tput_span", 64'(last_pop - first_pop), 64'd9);

        // Backpressure: stall 5 cycles once S3 is full
        fork
            begin
                for (int i = 0; i < 8; i++) send(i % 7);
                mux_postprocess_valid = 1'b0;
            end
            begin
                int t = 0;
                while (!post_out_valid && t < 50) begin
                    @(posedge clk); #1;
                    t++;
                end
                post_out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("bp_ready_low", 64'(mux_postprocess_ready), 64'd0);
                    @(posedge clk); #1;
                end
                post_out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with three beats in flight
        send(0);
        send(3);
        send(4);
        mux_postprocess_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(post_out_valid), 64'd0);
        chk("midrst_data", 64'(post_out), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_stale", 64'(post_out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(5);
        mux_postprocess_valid = 1'b0;
        wait_drain();

`ifdef POSTPROC_SAT_CNT_EN
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        chk("satcnt_clr", 64'(sat_cnt), 64'd0);
        send(6);
        send(6);
        mux_postprocess_valid = 1'b0;
        wait_drain();
        chk("satcnt_6", 64'(sat_cnt), 64'd6);
        send(6);
        mux_postprocess_valid = 1'b0;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        chk("satcnt_clr_wins", 64'(sat_cnt), 64'd0);
        wait_drain();
        chk("satcnt_after_clr", 64'(sat_cnt), 64'd0);
        send(1);
        mux_postprocess_valid = 1'b0;
        wait_drain();
        chk("satcnt_2", 64'(sat_cnt), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
